// File: rtl/fast_decrement_counter.sv
// Down-counter with a carry-free decrement, a three-state IDLE/RUN/DONE control
// FSM and a sticky self-check against a conventional subtractor.
module fast_decrement_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_vld,
  input  logic [W-1:0] load_dat,
  output logic         load_rdy,
  input  logic         dec_en,
  input  logic         abort,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done,
  output logic         fail
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] lower_zero;
  logic [W-1:0] onehot;
  logic [W-1:0] incl_mask;
  logic [W-1:0] fast_dec;
  logic [W-1:0] ref_dec;
  logic [W-1:0] cnt_d;
  logic         fail_d;

  // lower_zero[i] is set when every bit below i is clear, so ANDing with cnt
  // isolates the right-most 1 without a carry chain.
  always_comb begin
    lower_zero    = '0;
    lower_zero[0] = 1'b1;
    for (int unsigned i = 1; i < W; i++) begin
      lower_zero[i] = lower_zero[i-1] & ~cnt[i-1];
    end
    onehot = cnt & lower_zero;

    incl_mask      = '0;
    incl_mask[W-1] = onehot[W-1];
    for (int unsigned i = W - 1; i > 0; i--) begin
      incl_mask[i-1] = incl_mask[i] | onehot[i-1];
    end
    if (onehot == '0) begin
      incl_mask = '1;
    end
    fast_dec = cnt ^ incl_mask;
  end

  assign ref_dec = cnt - W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_vld) begin
          state_d = (load_dat == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dec_en && cnt == W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_rdy = (state_q == IDLE);
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
  end

  always_comb begin
    cnt_d = cnt;
    if (state_q == IDLE && load_vld) begin
      cnt_d = load_dat;
    end else if (state_q == RUN && !abort && dec_en) begin
      cnt_d = fast_dec;
    end
    fail_d = fail | ((state_q == RUN) && dec_en && (fast_dec != ref_dec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      fail <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      fail <= fail_d;
    end
  end

endmodule
